dc_frame_packer: RTL and testbench
==================================

# dc_frame_packer

Transmit-side packer for the DC/launch word stream. Accepts either a complete DC register frame (FRAME_WORDS words plus a target channel) or a 4-word launch command. Serializes it into 32-bit words on a FIFO write port, honouring FIFO-full backpressure. Its output is the exact word format consumed by the DC dispatcher on the far side of the FIFO: a DC frame header with a channel mask, or the 0xFFFF_FFFF launch marker followed by 4 words.

## Interface
- DAC_CHANNEL, 24, number of DAC channels; header bits [8+j] form the active-low channel mask, j < DAC_CHANNEL
- FRAME_WORDS, 62, words per DC frame, header included
- i_clk  input  1  clock; one clock domain
- i_rst  input  1  reset, asynchronous, active-high
- i_frame_valid  input  1  DC frame request
- o_frame_ready  output  1  frame accepted when valid && ready
- i_frame_words  input  FRAME_WORDS x 32  frame words; word 0 bits [7:0] are header low byte, bits [31:8] ignored
- i_channel  input  5  target channel
- i_launch_valid  input  1  launch request
- o_launch_ready  output  1  launch accepted when valid && ready
- i_launch_cmd  input  4 x 32  launch payload
- o_fifo_data  output  32  word to FIFO
- o_fifo_wr  output  1  FIFO write strobe
- i_fifo_full  input  1  FIFO full
- o_busy  output  1  packer not in IDLE
- o_done  output  1  one-cycle pulse after the last word of a packet is written
- o_err  output  1  one-cycle pulse when a frame with i_channel >= DAC_CHANNEL is dropped
- o_frames_sent  output  16  completed DC frames, wraps at 0xFFFF
- o_launches_sent  output  16  completed launches, wraps

## Operation
- States: IDLE, SEND_FRAME, SEND_LAUNCH. Word counter r_idx is 6 bits.
- IDLE:
  - o_launch_ready = 1.
  - o_frame_ready = !i_launch_valid, so a launch wins a simultaneous request.
- Launch accept:
  - Capture i_launch_cmd, set r_idx = 0, go to SEND_LAUNCH.
  - Words sent in order: 0xFFFF_FFFF, then cmd[0], cmd[1], cmd[2], cmd[3]. That is 5 words, r_idx 0..4.
- Frame accept with i_channel < DAC_CHANNEL:
  - Capture all words, set r_idx = 0, go to SEND_FRAME.
  - Word 0 is built as header = {~(24'b1 << i_channel), i_frame_words[0][7:0]}: exactly one mask bit is low, bit 8+i_channel.
  - Words 1..FRAME_WORDS-1 are copied unchanged.
  - A DC header therefore never equals 0xFFFF_FFFF.
- Frame accept with i_channel >= DAC_CHANNEL:
  - Handshake completes and nothing is written.
  - o_err pulses the next cycle; state stays IDLE.
- SEND states:
  - o_fifo_wr = !i_fifo_full (combinational).
  - o_fifo_data = current word mux of r_idx.
  - r_idx increments only on a write.
  - After the last word (r_idx = FRAME_WORDS-1 or 4) is written: next state IDLE, o_done pulses next cycle, the matching counter increments.
- Outside SEND states: o_fifo_wr = 0 and o_fifo_data = 0.
- Both ready outputs are 0 while busy. Requests are not queued.
- Capture buffers are stable for the whole send, so upstream may change inputs right after the handshake.

## Timing
- Reset values:
  - state IDLE, r_idx 0
  - o_fifo_wr 0, o_fifo_data 0
  - o_busy 0, o_done 0, o_err 0
  - counters 0
  - ready outputs follow IDLE, but handshakes while i_rst is high are ignored
- Handshake in cycle N → first write in N+1 if FIFO not full.
- With no backpressure:
  - Frame: writes in N+1..N+FRAME_WORDS. o_done and ready return in N+FRAME_WORDS+1. Minimum frame-to-frame period is FRAME_WORDS+1 cycles.
  - Launch: writes in N+1..N+5, o_done in N+6.
- i_fifo_full high stalls the sender in place: no write, no index change, o_fifo_data holds the pending word. Full may toggle every cycle.
- Full asserted on the final word delays o_done until that word is written.
- Reset mid-packet: immediate abort to IDLE and the partial packet is truncated. The system must reset the FIFO and the dispatcher together with the packer.
- Counters wrap 0xFFFF → 0x0000 with no flag.

## Test plan
- Frame, channel 3, FIFO never full:
  - 62 consecutive writes; word 0 = 0xFFFFF7xx; words 1..61 match the input.
  - o_done one cycle after the last write; o_frames_sent = 1.
- Launch with cmd = {0x44, 0x33, 0x22, 0x11}:
  - Writes 0xFFFF_FFFF, 0x11, 0x22, 0x33, 0x44 on 5 consecutive cycles.
  - o_launches_sent = 1.
- Simultaneous frame and launch requests in IDLE:
  - Launch is sent first and o_frame_ready is 0 in that cycle.
  - The frame is then accepted 6 cycles later and sent intact.
- Random i_fifo_full (about 50%) during a frame:
  - Exactly 62 writes, in order, none while full; o_fifo_data stable during stalls.
- Frame with i_channel = 24:
  - No writes, o_err one pulse, o_frames_sent unchanged, ready back high next cycle.
- i_rst asserted after 10 frame words:
  - o_fifo_wr drops immediately and state returns to IDLE.
  - A new launch after reset is sent correctly.

Source files
------------

// File: rtl/dc_frame_packer.sv
// Transmit-side packer: serializes a DC register frame (with channel-mask header) or a
// launch command (0xFFFF_FFFF marker + 4 words) onto a FIFO write port with full backpressure.
module dc_frame_packer #(
  parameter int unsigned DAC_CHANNEL = 24,
  parameter int unsigned FRAME_WORDS = 62
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_frame_valid,
  output logic                        o_frame_ready,
  input  logic [FRAME_WORDS-1:0][31:0] i_frame_words,
  input  logic [4:0]                  i_channel,
  input  logic                        i_launch_valid,
  output logic                        o_launch_ready,
  input  logic [3:0][31:0]            i_launch_cmd,
  output logic [31:0]                 o_fifo_data,
  output logic                        o_fifo_wr,
  input  logic                        i_fifo_full,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err,
  output logic [15:0]                 o_frames_sent,
  output logic [15:0]                 o_launches_sent
);

  typedef enum logic [1:0] {StIdle, StSendFrame, StSendLaunch} state_e;

  state_e                         state_q;
  logic [5:0]                     idx_q;
  logic [FRAME_WORDS-1:0][31:0]   frame_q;
  logic [3:0][31:0]               launch_q;
  logic                           done_q;
  logic                           err_q;
  logic [15:0]                    frames_q;
  logic [15:0]                    launches_q;

  logic        idle;
  logic        chan_ok;
  logic        launch_acc;
  logic        frame_acc;
  logic        wr;
  logic        last_word;
  logic [1:0]  launch_sel;
  logic [23:0] chan_mask;
  logic        unused_hdr;

  // Upper bits of the incoming header word are replaced by the channel mask.
  assign unused_hdr = ^i_frame_words[0][31:8];

  always_comb begin
    idle       = (state_q == StIdle);
    chan_ok    = (32'(i_channel) < DAC_CHANNEL);
    launch_acc = idle && i_launch_valid;
    frame_acc  = idle && !i_launch_valid && i_frame_valid;
    wr         = !idle && !i_fifo_full;
    launch_sel = 2'(idx_q - 6'd1);
    chan_mask  = ~(24'd1 << i_channel);
    last_word  = ((state_q == StSendFrame) && (idx_q == 6'(FRAME_WORDS - 1))) ||
                 ((state_q == StSendLaunch) && (idx_q == 6'd4));
  end

  always_comb begin
    o_fifo_data = 32'h0;
    unique case (state_q)
      StSendFrame:  o_fifo_data = frame_q[idx_q];
      StSendLaunch: o_fifo_data = (idx_q == 6'd0) ? 32'hFFFF_FFFF : launch_q[launch_sel];
      default:      o_fifo_data = 32'h0;
    endcase
  end

  assign o_fifo_wr       = wr;
  assign o_busy          = !idle;
  assign o_launch_ready  = idle;
  assign o_frame_ready   = idle && !i_launch_valid;
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign o_frames_sent   = frames_q;
  assign o_launches_sent = launches_q;

  // Capture buffers need no reset: they are only read after a handshake loads them.
  always_ff @(posedge i_clk) begin
    if (launch_acc) begin
      launch_q <= i_launch_cmd;
    end
    if (frame_acc && chan_ok) begin
      frame_q    <= i_frame_words;
      frame_q[0] <= {chan_mask, i_frame_words[0][7:0]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      idx_q      <= 6'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      frames_q   <= 16'd0;
      launches_q <= 16'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          idx_q <= 6'd0;
          if (launch_acc) begin
            state_q <= StSendLaunch;
          end else if (frame_acc) begin
            if (chan_ok) begin
              state_q <= StSendFrame;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StSendFrame, StSendLaunch: begin
          if (wr) begin
            if (last_word) begin
              state_q <= StIdle;
              idx_q   <= 6'd0;
              done_q  <= 1'b1;
              if (state_q == StSendFrame) begin
                frames_q <= frames_q + 16'd1;
              end else begin
                launches_q <= launches_q + 16'd1;
              end
            end else begin
              idx_q <= idx_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dc_frame_packer.sv
// Bench for dc_frame_packer: table of packets with random backpressure, checked every cycle
// against a queue-based model of the expected word stream, plus arbitration and reset sequences.
module tb_dc_frame_packer;

  localparam int FW = 62;
  localparam int DC = 24;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_frame_valid = 1'b0;
  logic                 o_frame_ready;
  logic [FW-1:0][31:0]  i_frame_words = '0;
  logic [4:0]           i_channel = 5'd0;
  logic                 i_launch_valid = 1'b0;
  logic                 o_launch_ready;
  logic [3:0][31:0]     i_launch_cmd = '0;
  logic [31:0]          o_fifo_data;
  logic                 o_fifo_wr;
  logic                 i_fifo_full = 1'b0;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;
  logic [15:0]          o_frames_sent;
  logic [15:0]          o_launches_sent;

  dc_frame_packer #(.DAC_CHANNEL(DC), .FRAME_WORDS(FW)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_frame_valid  (i_frame_valid),
    .o_frame_ready  (o_frame_ready),
    .i_frame_words  (i_frame_words),
    .i_channel      (i_channel),
    .i_launch_valid (i_launch_valid),
    .o_launch_ready (o_launch_ready),
    .i_launch_cmd   (i_launch_cmd),
    .o_fifo_data    (o_fifo_data),
    .o_fifo_wr      (o_fifo_wr),
    .i_fifo_full    (i_fifo_full),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err),
    .o_frames_sent  (o_frames_sent),
    .o_launches_sent(o_launches_sent)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit         is_launch;
    logic [4:0] channel;
    int         full_pct;
    bit         expect_err;
    int         exp_writes;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  bit          pend_launch, done_pend, err_pend, prev_stall, err_seen, l_acc, f_acc;
  logic [31:0] prev_data;
  logic [15:0] m_frames, m_launches;
  int          cyc = 0, write_cnt, l_cyc, f_cyc, done_cyc, full_pct = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: a packet is the list of words it must produce; the DUT is busy while any remain.
  task automatic monitor();
    bit          busy_m;
    logic [31:0] h;
    cyc++;
    if (i_rst) begin
      exp_q.delete();
      done_pend = 0; err_pend = 0; prev_stall = 0;
      m_frames = 0; m_launches = 0;
      chk("rst_wr", {31'b0, o_fifo_wr}, 0);
      chk("rst_busy", {31'b0, o_busy}, 0);
      chk("rst_data", o_fifo_data, 0);
      chk("rst_frames", {16'b0, o_frames_sent}, 0);
      return;
    end
    busy_m = (exp_q.size() != 0);
    chk("done", {31'b0, o_done}, {31'b0, done_pend});
    chk("err", {31'b0, o_err}, {31'b0, err_pend});
    if (o_done) done_cyc = cyc;
    if (o_err) err_seen = 1;
    done_pend = 0;
    err_pend  = 0;
    chk("frames_sent", {16'b0, o_frames_sent}, {16'b0, m_frames});
    chk("launches_sent", {16'b0, o_launches_sent}, {16'b0, m_launches});
    chk("busy", {31'b0, o_busy}, {31'b0, busy_m});
    chk("launch_ready", {31'b0, o_launch_ready}, {31'b0, !busy_m});
    chk("frame_ready", {31'b0, o_frame_ready}, {31'b0, !busy_m && !i_launch_valid});
    if (!busy_m) chk("idle_data", o_fifo_data, 0);
    if (prev_stall && busy_m) chk("stall_hold", o_fifo_data, prev_data);
    prev_stall = busy_m && i_fifo_full;
    prev_data  = o_fifo_data;
    chk("wr_strobe", {31'b0, o_fifo_wr}, {31'b0, busy_m && !i_fifo_full});
    if (o_fifo_wr && busy_m) begin
      write_cnt++;
      chk("word", o_fifo_data, exp_q.pop_front());
      if (exp_q.size() == 0) begin
        done_pend = 1;
        if (pend_launch) m_launches++;
        else m_frames++;
      end
    end
    if (!busy_m) begin
      if (i_launch_valid) begin
        exp_q.push_back(32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) exp_q.push_back(i_launch_cmd[i]);
        pend_launch = 1;
        l_acc = 1;
        l_cyc = cyc;
      end else if (i_frame_valid) begin
        f_acc = 1;
        f_cyc = cyc;
        if (i_channel < DC) begin
          h = 32'hFFFF_FFFF;
          h[8 + i_channel] = 1'b0;
          h[7:0] = i_frame_words[0][7:0];
          exp_q.push_back(h);
          for (int i = 1; i < FW; i++) exp_q.push_back(i_frame_words[i]);
          pend_launch = 0;
        end else begin
          err_pend = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
    i_fifo_full = ($urandom_range(99) < full_pct);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < FW; i++) i_frame_words[i] = $urandom;
    for (int i = 0; i < 4; i++) i_launch_cmd[i] = $urandom;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 3000 && (exp_q.size() != 0 || done_pend || err_pend); t++) step();
    if (exp_q.size() != 0 || done_pend || err_pend) fail(name);
  endtask

  task automatic run_vec(input vec_t v);
    randomize_inputs();
    i_channel = v.channel;
    write_cnt = 0; err_seen = 0; l_acc = 0; f_acc = 0; done_cyc = 0;
    full_pct = v.full_pct;
    if (v.is_launch) i_launch_valid = 1'b1;
    else i_frame_valid = 1'b1;
    for (int t = 0; t < 100 && !(l_acc || f_acc); t++) step();
    if (!(l_acc || f_acc)) fail("handshake");
    i_launch_valid = 1'b0;
    i_frame_valid  = 1'b0;
    randomize_inputs();
    drain("drain");
    chk("write_count", write_cnt, v.exp_writes);
    chk("err_pulse", {31'b0, err_seen}, {31'b0, v.expect_err});
    if (v.full_pct == 0 && !v.expect_err)
      chk("done_latency", done_cyc - (v.is_launch ? l_cyc : f_cyc), v.exp_writes + 1);
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0] = '{0, 5'd3,  0,  0, FW};
    tbl[1] = '{1, 5'd0,  0,  0, 5};
    tbl[2] = '{0, 5'd0,  50, 0, FW};
    tbl[3] = '{0, 5'd23, 30, 0, FW};
    tbl[4] = '{0, 5'd24, 0,  1, 0};
    tbl[5] = '{0, 5'd31, 50, 1, 0};
    tbl[6] = '{1, 5'd9,  50, 0, 5};
    tbl[7] = '{0, 5'd12, 90, 0, FW};
    for (int i = 8; i < 16; i++) begin
      tbl[i].is_launch  = ($urandom_range(3) == 0);
      tbl[i].channel    = 5'($urandom_range(31));
      tbl[i].full_pct   = $urandom_range(60);
      tbl[i].expect_err = !tbl[i].is_launch && (tbl[i].channel >= 5'd24);
      tbl[i].exp_writes = tbl[i].is_launch ? 5 : (tbl[i].expect_err ? 0 : FW);
    end

    i_rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    i_rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) run_vec(tbl[i]);

    // Simultaneous requests: launch first, frame taken six cycles later.
    full_pct = 0;
    randomize_inputs();
    i_channel = 5'd5;
    l_acc = 0; f_acc = 0; write_cnt = 0;
    i_launch_valid = 1'b1;
    i_frame_valid  = 1'b1;
    for (int t = 0; t < 50 && !l_acc; t++) step();
    if (!l_acc) fail("arb_launch");
    i_launch_valid = 1'b0;
    for (int t = 0; t < 50 && !f_acc; t++) step();
    if (!f_acc) fail("arb_frame");
    i_frame_valid = 1'b0;
    chk("arb_gap", f_cyc - l_cyc, 6);
    drain("arb_drain");
    chk("arb_writes", write_cnt, 5 + FW);

    // Reset after ten frame words, then a clean launch.
    randomize_inputs();
    i_channel = 5'd7;
    f_acc = 0; write_cnt = 0;
    i_frame_valid = 1'b1;
    for (int t = 0; t < 50 && !f_acc; t++) step();
    i_frame_valid = 1'b0;
    for (int t = 0; t < 200 && write_cnt < 10; t++) step();
    if (write_cnt < 10) fail("rst_wait");
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    step();
    run_vec('{1, 5'd0, 0, 0, 5});
    chk("post_rst_launches", {16'b0, o_launches_sent}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
